// File: rtl/game_ctrl.sv
// Central sequencer for the dinosaur game: arms on start, runs from a vertical-blank
// edge, detects crashes from per-frame dinosaur/cactus overlap and schedules scroll speed.
module game_ctrl #(
  parameter int unsigned SPEED_INIT       = 1,
  parameter int unsigned SPEED_MAX        = 8,
  parameter int unsigned FRAMES_PER_LEVEL = 600,
  parameter int unsigned HOLDOFF_FRAMES   = 30,
  parameter int unsigned COLL_MIN_CYC     = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        start,
  input  logic        vs,
  input  logic        px_dinosaur,
  input  logic        px_cactus,
  output logic        game_status,
  output logic [1:0]  state,
  output logic [3:0]  speed,
  output logic [15:0] frames,
  output logic        new_game,
  output logic        crash
);

  localparam int unsigned LW = $clog2(FRAMES_PER_LEVEL);
  localparam int unsigned OW = $clog2(COLL_MIN_CYC + 1);
  localparam int unsigned HW = (HOLDOFF_FRAMES == 0) ? 1 : $clog2(HOLDOFF_FRAMES + 1);

  localparam logic [LW-1:0] LVL_LAST = LW'(FRAMES_PER_LEVEL - 1);
  localparam logic [OW-1:0] OVL_MAX  = OW'(COLL_MIN_CYC);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLDOFF_FRAMES);
  localparam logic [3:0]    SPD_INIT = 4'(SPEED_INIT);
  localparam logic [3:0]    SPD_MAX  = 4'(SPEED_MAX);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RUNNING = 2'd2,
    CRASHED = 2'd3
  } state_t;

  state_t        st;
  logic          vs_d;
  logic          start_d;
  logic [LW-1:0] lvl_cnt;
  logic [OW-1:0] ovl_cnt;
  logic [HW-1:0] hold_cnt;

  logic frame_tick;
  logic start_rise;
  logic overlap;

  assign frame_tick = vs_d & ~vs;
  assign start_rise = start & ~start_d;
  assign overlap    = px_dinosaur & px_cactus;

  assign state       = st;
  assign game_status = (st == RUNNING);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      st       <= IDLE;
      vs_d     <= 1'b1;
      start_d  <= 1'b1;
      speed    <= SPD_INIT;
      frames   <= '0;
      lvl_cnt  <= '0;
      ovl_cnt  <= '0;
      hold_cnt <= '0;
      new_game <= 1'b0;
      crash    <= 1'b0;
    end else begin
      vs_d     <= vs;
      start_d  <= start;
      new_game <= 1'b0;
      crash    <= 1'b0;
      unique case (st)
        IDLE: begin
          if (start_rise) st <= ARMED;
        end
        ARMED: begin
          if (frame_tick) begin
            st       <= RUNNING;
            speed    <= SPD_INIT;
            frames   <= '0;
            lvl_cnt  <= '0;
            ovl_cnt  <= '0;
            new_game <= 1'b1;
          end
        end
        RUNNING: begin
          // Overlap is counted per frame; the tick cycle's own overlap starts the new count.
          if (frame_tick) ovl_cnt <= overlap ? OW'(1) : '0;
          else if (overlap && ovl_cnt != OVL_MAX) ovl_cnt <= ovl_cnt + 1'b1;
          if (frame_tick) begin
            if (frames != '1) frames <= frames + 1'b1;
            if (lvl_cnt == LVL_LAST) begin
              lvl_cnt <= '0;
              if (speed < SPD_MAX) speed <= speed + 1'b1;
            end else begin
              lvl_cnt <= lvl_cnt + 1'b1;
            end
          end
          if (ovl_cnt == OVL_MAX) begin
            st       <= CRASHED;
            crash    <= 1'b1;
            hold_cnt <= '0;
          end
        end
        CRASHED: begin
          if (frame_tick && hold_cnt != HOLD_MAX) hold_cnt <= hold_cnt + 1'b1;
          if (start_rise && hold_cnt == HOLD_MAX) st <= ARMED;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_ctrl.sv
// Randomised bench for game_ctrl: an integer-level reference model predicts state,
// speed and frames each cycle and queues the new_game/crash pulses it expects.
module tb_game_ctrl;

  localparam int SPEED_INIT = 1;
  localparam int SPEED_MAX  = 8;
  localparam int FPL        = 600;
  localparam int HOLD       = 30;
  localparam int COLL       = 4;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        start = 1'b1;
  logic        vs = 1'b1;
  logic        px_dinosaur = 1'b0;
  logic        px_cactus = 1'b0;
  logic        game_status;
  logic [1:0]  state;
  logic [3:0]  speed;
  logic [15:0] frames;
  logic        new_game;
  logic        crash;

  game_ctrl #(
    .SPEED_INIT      (SPEED_INIT),
    .SPEED_MAX       (SPEED_MAX),
    .FRAMES_PER_LEVEL(FPL),
    .HOLDOFF_FRAMES  (HOLD),
    .COLL_MIN_CYC    (COLL)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .start      (start),
    .vs         (vs),
    .px_dinosaur(px_dinosaur),
    .px_cactus  (px_cactus),
    .game_status(game_status),
    .state      (state),
    .speed      (speed),
    .frames     (frames),
    .new_game   (new_game),
    .crash      (crash)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    int kind;   // 1 = new_game, 2 = crash
    int spd;
    int frm;
  } ev_t;
  ev_t evq[$];

  // Reference model: run progress is the raw count of frame ticks since the run began.
  int m_st = 0;
  int m_ticks = 0;
  int m_ovl = 0;
  int m_hold = 0;
  bit m_vsd = 1'b1;
  bit m_startd = 1'b1;

  function automatic int exp_speed();
    int s;
    s = SPEED_INIT + m_ticks / FPL;
    return (s > SPEED_MAX) ? SPEED_MAX : s;
  endfunction

  function automatic int exp_frames();
    return (m_ticks > 65535) ? 65535 : m_ticks;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  initial begin : ref_model
    bit tick, rise, ov, hit, ready;
    ev_t e;
    forever begin
      @(posedge CLK);
      if (RESET) begin
        m_st = 0; m_ticks = 0; m_ovl = 0; m_hold = 0;
        m_vsd = 1'b1; m_startd = 1'b1;
      end else begin
        tick = m_vsd && !vs;
        rise = start && !m_startd;
        ov   = px_dinosaur && px_cactus;
        case (m_st)
          0: if (rise) m_st = 1;
          1: if (tick) begin
               m_st = 2; m_ticks = 0; m_ovl = 0;
               e.kind = 1; e.spd = exp_speed(); e.frm = exp_frames();
               evq.push_back(e);
             end
          2: begin
               hit = (m_ovl >= COLL);
               if (tick) begin
                 m_ticks++;
                 m_ovl = ov ? 1 : 0;
               end else if (ov && m_ovl < COLL) begin
                 m_ovl++;
               end
               if (hit) begin
                 m_st = 3; m_hold = 0;
                 e.kind = 2; e.spd = exp_speed(); e.frm = exp_frames();
                 evq.push_back(e);
               end
             end
          default: begin
               ready = (m_hold == HOLD);
               if (tick && m_hold < HOLD) m_hold++;
               if (rise && ready) m_st = 1;
             end
        endcase
        m_vsd = vs;
        m_startd = start;
      end
    end
  end

  initial begin : monitor
    ev_t e;
    int act_k;
    @(posedge CLK);
    forever begin
      @(negedge CLK);
      chk("state", int'(state), m_st);
      chk("speed", int'(speed), exp_speed());
      chk("frames", int'(frames), exp_frames());
      chk("game_status", int'(game_status), (m_st == 2) ? 1 : 0);
      if (new_game || crash) begin
        act_k = (new_game && crash) ? 3 : (new_game ? 1 : 2);
        if (evq.size() == 0) begin
          chk("unexpected_event", act_k, 0);
        end else begin
          e = evq.pop_front();
          chk("event_kind", act_k, e.kind);
          chk("event_speed", int'(speed), e.spd);
          chk("event_frames", int'(frames), e.frm);
        end
      end else if (evq.size() != 0) begin
        e = evq.pop_front();
        chk("missed_event", 0, e.kind);
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion at %0t", $time);
    $fatal(1, "simulation time limit exceeded");
  end

  task automatic drive(input bit v, input bit s, input bit pd, input bit pc);
    @(posedge CLK);
    #2;
    vs = v; start = s; px_dinosaur = pd; px_cactus = pc;
  endtask

  // One frame: vs low in cycle 0, high afterwards. mode 1 = random sparse overlap
  // (never in the tick cycle, so at most len-1 overlaps), otherwise mask-driven overlap.
  task automatic frame(input int len, input int mode, input logic [31:0] mask);
    bit v, pd, pc;
    for (int i = 0; i < len; i++) begin
      v = (i != 0);
      if (mode == 1) begin
        pd = 1'($urandom_range(0, 1));
        pc = v && ($urandom_range(0, 1) == 1);
      end else begin
        pd = mask[i];
        pc = mask[i];
      end
      drive(v, 1'b0, pd, pc);
    end
  endtask

  initial begin : stimulus
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("reset_state", int'(state), 0);
    chk("reset_speed", int'(speed), 1);
    chk("reset_frames", int'(frames), 0);
    chk("reset_game_status", int'(game_status), 0);

    @(posedge CLK);
    #2 RESET = 1'b0;
    repeat (5) drive(1, 1, 0, 0);
    @(negedge CLK);
    chk("held_start_stays_idle", int'(state), 0);

    drive(1, 0, 0, 0);
    drive(1, 1, 0, 0);
    drive(1, 0, 0, 0);
    @(negedge CLK);
    chk("armed_after_start", int'(state), 1);
    repeat (48) drive(1, 0, 0, 0);
    drive(0, 0, 0, 0);
    drive(1, 0, 0, 0);
    @(negedge CLK);
    chk("running_after_vs_fall", int'(state), 2);
    chk("game_status_running", int'(game_status), 1);
    chk("new_game_pulse", int'(new_game), 1);
    drive(1, 0, 0, 0);
    @(negedge CLK);
    chk("new_game_single", int'(new_game), 0);

    repeat (600) frame(4, 1, '0);
    @(negedge CLK);
    chk("speed_level1", int'(speed), 2);
    chk("frames_600", int'(frames), 600);
    repeat (4200) frame(4, 1, '0);
    @(negedge CLK);
    chk("speed_saturated", int'(speed), 8);
    chk("frames_4800", int'(frames), 4800);

    frame(20, 2, 32'h0000_1110);
    frame(20, 2, 32'h0000_1110);
    @(negedge CLK);
    chk("isolated_overlap_no_crash", int'(state), 2);
    frame(20, 2, 32'h0000_01E0);
    @(negedge CLK);
    chk("crash_state", int'(state), 3);
    chk("crash_game_status", int'(game_status), 0);
    chk("crash_frames_held", int'(frames), 4803);

    repeat (10) frame(8, 2, '0);
    drive(1, 1, 0, 0);
    drive(1, 0, 0, 0);
    @(negedge CLK);
    chk("holdoff_ignores_start", int'(state), 3);
    repeat (25) frame(8, 2, '0);
    @(negedge CLK);
    chk("holdoff_frames_held", int'(frames), 4803);
    drive(1, 1, 0, 0);
    drive(1, 0, 0, 0);
    @(negedge CLK);
    chk("rearm_after_holdoff", int'(state), 1);
    frame(8, 2, '0);
    @(negedge CLK);
    chk("new_run_state", int'(state), 2);
    chk("new_run_speed", int'(speed), 1);
    chk("new_run_frames", int'(frames), 0);

    repeat (2400) frame(4, 1, '0);
    @(negedge CLK);
    chk("speed_5", int'(speed), 5);
    @(posedge CLK);
    #2 RESET = 1'b1;
    @(posedge CLK);
    #2 RESET = 1'b0;
    @(negedge CLK);
    chk("midrun_reset_state", int'(state), 0);
    chk("midrun_reset_speed", int'(speed), 1);
    chk("midrun_reset_frames", int'(frames), 0);
    chk("midrun_reset_no_crash", int'(crash), 0);

    for (int i = 0; i < 4000; i++) begin
      @(posedge CLK);
      #2;
      RESET       = ($urandom_range(0, 499) == 0);
      vs          = ($urandom_range(0, 5) != 0);
      start       = ($urandom_range(0, 7) == 0);
      px_dinosaur = 1'($urandom_range(0, 1));
      px_cactus   = 1'($urandom_range(0, 1));
    end

    @(posedge CLK);
    #2 RESET = 1'b0;
    repeat (3) drive(1, 0, 0, 0);
    @(negedge CLK);
    chk("event_queue_drained", evq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/game_ctrl.md
Name: game_ctrl

Overview:
- Central sequencer for the dinosaur game. It replaces the ad hoc game_status logic with an explicit state machine.
- Arms the game on START, begins the run only at a vertical-blank edge, and detects a crash from filtered dinosaur/cactus overlap.
- Enforces a post-crash hold-off, and schedules the scroll speed consumed by ground and cactus.
- Sits between the button/VGA timing signals and the Jump, Ground, Cactus and Score blocks.

Parameters:
SPEED_INIT, 1, speed value loaded at reset and at every new run (4-bit)
SPEED_MAX, 8, saturation ceiling for speed
FRAMES_PER_LEVEL, 600, frames of running per speed increment (≥2)
HOLDOFF_FRAMES, 30, frames after a crash during which start is ignored
COLL_MIN_CYC, 4, CLK cycles of overlap within one frame that count as a crash (≥1)

Ports:
CLK  input  1  system clock; all logic on posedge
RESET  input  1  synchronous, active-high reset
start  input  1  start button, active-high, already synchronised to CLK
vs  input  1  VGA vertical sync; low = blanking
px_dinosaur  input  1  dinosaur pixel active at current scan position
px_cactus  input  1  cactus pixel active at current scan position
game_status  output  1  1 while RUNNING
state  output  2  0=IDLE 1=ARMED 2=RUNNING 3=CRASHED
speed  output  4  current scroll speed
frames  output  16  frames elapsed in current run, saturating at 16'hFFFF
new_game  output  1  one-cycle pulse on the ARMED->RUNNING transition
crash  output  1  one-cycle pulse on the RUNNING->CRASHED transition

Behaviour:
- Reset:
  - RESET high at a posedge: state=IDLE, speed=SPEED_INIT, frames=0, overlap/level/hold-off counters=0, new_game=crash=0, internal vs_d=1, start_d=1.
  - start_d=1 means a button held through reset does not trigger.
  - RESET has priority over every other event, including mid-run.
- Derived strobes (all outputs registered; no combinational input-to-output path):
  - frame_tick = vs_d & ~vs, where vs_d is vs registered.
  - start_rise = start & ~start_d.
- IDLE:
  - game_status=0.
  - start_rise -> ARMED next cycle.
- ARMED:
  - start is ignored.
  - On frame_tick -> RUNNING. In the same cycle: speed<=SPEED_INIT, frames<=0, level counter<=0, overlap counter<=0, new_game<=1 for exactly one cycle.
- RUNNING (game_status=1):
  - Overlap counter increments each cycle px_dinosaur&px_cactus=1, saturating at COLL_MIN_CYC.
  - On frame_tick the overlap counter loads (px_dinosaur&px_cactus ? 1 : 0), i.e. it counts per frame.
  - When the registered count equals COLL_MIN_CYC -> CRASHED next cycle. In that cycle crash pulses 1, hold-off counter<=0, and game_status falls.
  - Per frame_tick: frames increments (saturating). The level counter increments; on reaching FRAMES_PER_LEVEL-1 it wraps to 0 and speed<=min(speed+1, SPEED_MAX).
  - Crash detection and frame_tick in the same cycle: the crash wins. speed and frames still update from that tick.
- CRASHED:
  - game_status=0. speed and frames are held, so the score stays visible.
  - Hold-off counter increments on each frame_tick, saturating at HOLDOFF_FRAMES.
  - start_rise is honoured only when hold-off==HOLDOFF_FRAMES -> ARMED. Before that it is ignored and not remembered.
  - HOLDOFF_FRAMES=0: start is accepted immediately.
- Other rules:
  - A start held continuously across CRASHED never re-arms; a fresh rising edge is required.
  - State encoding 2'b11 is CRASHED. There are no unreachable states. Counter widths are sized with $clog2 of the parameters.

Test Plan:
- RESET=1 for 3 cycles while start=1 -> state=0, speed=1, frames=0, game_status=0. Releasing RESET with start still high -> stays IDLE.
- start pulse, then vs falls 50 cycles later -> ARMED within 2 cycles of the pulse. RUNNING, new_game=1 for exactly one cycle, and game_status=1 on the cycle after the vs fall is sampled.
- RUNNING with 3 isolated overlap cycles in one frame, 3 more in the next -> no crash. 4 consecutive overlap cycles in a frame -> crash pulse one cycle, state=3, game_status=0, frames held.
- 600 frame_ticks while RUNNING -> speed 1->2. Continue to 4800 ticks -> speed saturates at 8. frames=4800.
- Crash, then start rise after 10 frames -> stays CRASHED. Start rise after 30 frames -> ARMED, and on the next frame_tick speed resets to 1 and frames to 0.
- RESET asserted mid-RUNNING at speed 5 -> next cycle IDLE, speed=1, frames=0, no crash pulse.
